// File: rtl/vdegen_if.sv
// Signal bundle for the vertical display-enable generator (vdegen).
// Mode selects and the line-timer sync go in; vertical timing comes out.
interface vdegen_if;
    logic       mde1;    // monochrome (high-resolution) mode select
    logic       ntsc;    // 60 Hz colour timing when 1, 50 Hz when 0
    logic       ihsync;  // horizontal sync from the line timer, active-high
    logic       vblank;  // 1 = visible line, 0 = vertical blank
    logic       vde;     // vertical display enable
    logic       vsync;   // vertical sync, active-high
    logic [8:0] vcnt;    // current line number
    logic       sof;     // one-cycle pulse at each frame wrap

    modport master (
        output mde1, ntsc, ihsync,
        input  vblank, vde, vsync, vcnt, sof
    );

    modport slave (
        input  mde1, ntsc, ihsync,
        output vblank, vde, vsync, vcnt, sof
    );
endinterface

// File: rtl/vdegen.sv
// vdegen: vertical line counter and vertical timing generator.
// Counts rising edges of ihsync, wraps at the last line of the selected
// mode (MONO/NTSC/PAL) and produces registered vde, vblank, vsync and a
// start-of-frame pulse.
// Optional macro VDEGEN_MODE_LATCH_EN: when defined, the mode selects are
// latched at each frame wrap (and on the first strobe after reset), so a
// mode change only takes effect at the next frame boundary.
module vdegen (
    input  logic    m2clock,
    input  logic    porb,
    vdegen_if.slave bus
);

    localparam logic [1:0] MODE_MONO = 2'd0;
    localparam logic [1:0] MODE_NTSC = 2'd1;
    localparam logic [1:0] MODE_PAL  = 2'd2;

    logic       hs_q;
    logic       strobe;
    logic [1:0] live_mode;
    logic [1:0] mode;
    logic [8:0] last;
    logic [8:0] ds;
    logic [8:0] de;
    logic [8:0] bs;
    logic [8:0] be;
    logic [8:0] vs_start;
    logic [8:0] next_cnt;
    logic       wrap;

    logic [8:0] vcnt_q;
    logic       vde_q;
    logic       vblank_q;
    logic       vsync_q;
    logic       sof_q;

    // Register ihsync so its rising edge can be detected.
    // NOTE: the copy resets to 1 so an ihsync already high at reset release
    // is not mistaken for a fresh rising edge.
    always_ff @(posedge m2clock or negedge porb) begin
        if (!porb) begin
            hs_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignment for every flop, so all state
            // updates see the pre-edge values regardless of statement order.
            hs_q <= bus.ihsync;
        end
    end

    assign strobe = bus.ihsync & ~hs_q;

    assign live_mode = bus.mde1 ? MODE_MONO : (bus.ntsc ? MODE_NTSC : MODE_PAL);

`ifdef VDEGEN_MODE_LATCH_EN
    logic [1:0] mode_q;
    logic       mode_fresh;

    // Until the first strobe after reset the live selects are used; that
    // strobe and every wrap thereafter capture them for the next frame.
    assign mode = mode_fresh ? live_mode : mode_q;

    // Latch the mode selects on the first strobe and at each frame wrap.
    always_ff @(posedge m2clock or negedge porb) begin
        if (!porb) begin
            mode_q     <= MODE_PAL;
            mode_fresh <= 1'b1;
        end else if (strobe) begin
            mode_fresh <= 1'b0;
            if (mode_fresh || wrap) begin
                mode_q <= live_mode;
            end
        end
    end
`else
    assign mode = live_mode;
`endif

    // Per-mode line limits and compare points.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a
        // signal unassigned (which would infer a latch).
        last = 9'd312;
        ds   = 9'd63;
        de   = 9'd263;
        bs   = 9'd25;
        be   = 9'd309;
        case (mode)
            MODE_MONO: begin
                last = 9'd500;
                ds   = 9'd34;
                de   = 9'd434;
                bs   = 9'd1;
                be   = 9'd500;
            end
            MODE_NTSC: begin
                last = 9'd262;
                ds   = 9'd34;
                de   = 9'd234;
                bs   = 9'd16;
                be   = 9'd259;
            end
            default: ;
        endcase
    end

    assign vs_start = last - 9'd2;

    // Any count at or beyond the last line wraps, which also recovers a
    // count left out of range by a mid-frame mode change.
    assign next_cnt = (vcnt_q >= last) ? 9'd0 : vcnt_q + 9'd1;
    assign wrap     = (next_cnt == 9'd0);

    // Advance the line counter and update the timing flags on each strobe.
    always_ff @(posedge m2clock or negedge porb) begin
        if (!porb) begin
            vcnt_q   <= 9'd0;
            vde_q    <= 1'b0;
            vblank_q <= 1'b0;
            vsync_q  <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            sof_q <= 1'b0;
            if (strobe) begin
                vcnt_q  <= next_cnt;
                sof_q   <= wrap;
                vsync_q <= (next_cnt >= vs_start);
                // Clear compares are tested first so they win a tie.
                if (next_cnt == de) begin
                    vde_q <= 1'b0;
                end else if (next_cnt == ds) begin
                    vde_q <= 1'b1;
                end
                if (next_cnt == be) begin
                    vblank_q <= 1'b0;
                end else if (next_cnt == bs) begin
                    vblank_q <= 1'b1;
                end
            end
        end
    end

    assign bus.vcnt   = vcnt_q;
    assign bus.vde    = vde_q;
    assign bus.vblank = vblank_q;
    assign bus.vsync  = vsync_q;
    assign bus.sof    = sof_q;

endmodule

// File: tb/tb_vdegen.sv
// Self-checking bench for vdegen. A behavioural line model pushes the
// expected outputs of every line strobe into a queue; the entry is popped
// and compared once the DUT has registered that strobe.
module tb_vdegen;

    typedef struct packed {
        logic [8:0] vcnt;
        logic       sof;
        logic       vde;
        logic       vblank;
        logic       vsync;
    } exp_t;

    // Mode index: 0 = MONO, 1 = NTSC, 2 = PAL.
    int last_t [3] = '{500, 262, 312};
    int ds_t   [3] = '{34, 34, 63};
    int de_t   [3] = '{434, 234, 263};
    int bs_t   [3] = '{1, 16, 25};
    int be_t   [3] = '{500, 259, 309};

    logic m2clock = 1'b0;
    logic porb;

    vdegen_if bus ();

    vdegen dut (
        .m2clock (m2clock),
        .porb    (porb),
        .bus     (bus)
    );

    always #5 m2clock = ~m2clock;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    int m_vcnt;
    int m_mode;
    bit m_fresh;
    bit full_chk;

    int cnt_vde, cnt_vbl0, cnt_vs, cnt_sof;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic exp_t model_step();
        int   live, eff, nx;
        exp_t e;
        live = bus.mde1 ? 0 : (bus.ntsc ? 1 : 2);
`ifdef VDEGEN_MODE_LATCH_EN
        if (m_fresh) begin
            m_mode  = live;
            m_fresh = 1'b0;
        end
        eff = m_mode;
`else
        eff = live;
`endif
        nx = (m_vcnt >= last_t[eff]) ? 0 : m_vcnt + 1;
`ifdef VDEGEN_MODE_LATCH_EN
        if (nx == 0) m_mode = live;
`endif
        m_vcnt   = nx;
        e.vcnt   = nx[8:0];
        e.sof    = (nx == 0);
        e.vde    = (nx >= ds_t[eff]) && (nx < de_t[eff]);
        e.vblank = (nx >= bs_t[eff]) && (nx < be_t[eff]);
        e.vsync  = (nx >= last_t[eff] - 2);
        return e;
    endfunction

    task automatic clear_counts();
        cnt_vde  = 0;
        cnt_vbl0 = 0;
        cnt_vs   = 0;
        cnt_sof  = 0;
    endtask

    // One ihsync pulse: strobe, compare against the scoreboard, then
    // confirm the outputs hold and sof drops once the strobe is gone.
    task automatic line();
        exp_t e;
        @(negedge m2clock);
        bus.ihsync = 1'b1;
        exp_q.push_back(model_step());
        @(negedge m2clock);
        e = exp_q.pop_front();
        check("line_cnt_sof", {bus.vcnt, bus.sof}, {e.vcnt, e.sof});
        if (full_chk)
            check("line_flags", {bus.vde, bus.vblank, bus.vsync}, {e.vde, e.vblank, e.vsync});
        cnt_vde  += int'(bus.vde);
        cnt_vbl0 += int'(!bus.vblank);
        cnt_vs   += int'(bus.vsync);
        cnt_sof  += int'(bus.sof);
        bus.ihsync = 1'b0;
        @(negedge m2clock);
        check("hold", {bus.vcnt, bus.sof}, {e.vcnt, 1'b0});
    endtask

    task automatic do_reset(input logic mono, input logic n60);
        @(negedge m2clock);
        #2;
        porb       = 1'b0;
        bus.ihsync = 1'b1;
        bus.mde1   = mono;
        bus.ntsc   = n60;
        #1;
        check("reset_async_zero", {bus.vcnt, bus.vde, bus.vblank, bus.vsync, bus.sof}, 32'd0);
        @(negedge m2clock);
        porb = 1'b1;
        repeat (3) @(negedge m2clock);
        check("no_strobe_high_at_release", {bus.vcnt, bus.sof}, 32'd0);
        bus.ihsync = 1'b0;
        @(negedge m2clock);
        m_vcnt   = 0;
        m_mode   = 2;
        m_fresh  = 1'b1;
        full_chk = 1'b1;
        exp_q.delete();
        clear_counts();
    endtask

    initial begin
        int n;
        porb       = 1'b0;
        bus.ihsync = 1'b0;
        bus.mde1   = 1'b0;
        bus.ntsc   = 1'b0;
        m_vcnt     = 0;
        m_mode     = 2;
        m_fresh    = 1'b1;
        full_chk   = 1'b1;
        clear_counts();
        #12;
        check("reset_state", {bus.vcnt, bus.vde, bus.vblank, bus.vsync, bus.sof}, 32'd0);

        // PAL full frame.
        do_reset(1'b0, 1'b0);
        repeat (313) line();
        check("pal_vde_lines", cnt_vde, 200);
        check("pal_vblank0_lines", cnt_vbl0, 29);
        check("pal_vsync_lines", cnt_vs, 3);
        check("pal_sof_pulses", cnt_sof, 1);
        check("pal_end_vcnt", bus.vcnt, 0);

        // ihsync held high yields one strobe; a second edge yields another.
        n = int'(bus.vcnt);
        @(negedge m2clock);
        bus.ihsync = 1'b1;
        repeat (50) @(negedge m2clock);
        check("held_high_single", bus.vcnt, n + 1);
        bus.ihsync = 1'b0;
        repeat (2) @(negedge m2clock);
        bus.ihsync = 1'b1;
        repeat (2) @(negedge m2clock);
        bus.ihsync = 1'b0;
        @(negedge m2clock);
        check("held_high_total", bus.vcnt, n + 2);

        // NTSC full frame.
        do_reset(1'b0, 1'b1);
        repeat (263) line();
        check("ntsc_vde_lines", cnt_vde, 200);
        check("ntsc_vblank0_lines", cnt_vbl0, 20);
        check("ntsc_vsync_lines", cnt_vs, 3);
        check("ntsc_sof_pulses", cnt_sof, 1);

        // MONO full frame.
        do_reset(1'b1, 1'b0);
        repeat (501) line();
        check("mono_vde_lines", cnt_vde, 400);
        check("mono_vblank0_lines", cnt_vbl0, 2);
        check("mono_sof_pulses", cnt_sof, 1);
        check("mono_end_vcnt", bus.vcnt, 0);

        // Mode change MONO -> PAL at line 400.
        do_reset(1'b1, 1'b0);
        repeat (400) line();
        check("switch_at_400", bus.vcnt, 400);
        full_chk = 1'b0;
        bus.mde1 = 1'b0;
        n = 0;
        do begin
            line();
            n++;
        end while (bus.vcnt != 9'd0 && n < 600);
`ifdef VDEGEN_MODE_LATCH_EN
        check("switch_lines_to_wrap", n, 101);
`else
        check("switch_lines_to_wrap", n, 1);
`endif
        n = 0;
        do begin
            line();
            n++;
        end while (bus.vcnt != 9'd0 && n < 600);
        check("frame_after_switch", n, 313);

        // Reset mid-frame while vde is high.
        do_reset(1'b0, 1'b0);
        repeat (150) line();
        check("pre_reset_vde", {bus.vcnt, bus.vde}, {9'd150, 1'b1});
        do_reset(1'b0, 1'b0);
        line();
        check("first_after_reset", bus.vcnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
